dm_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU data port and the word-addressed `mem` block (1-cycle registered read, synchronous write). It serves hits in zero wait cycles. On a miss it stalls the CPU, writes back a dirty victim line word-by-word, then refills the line word-by-word. It keeps access and miss counters for benchmark runs.

---
 rtl/dm_cache.sv | 193 +++++++++++++++++++
 tb/tb_dm_cache.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache
//  Description : Direct-mapped, write-back, write-allocate data cache between
//                the CPU data port and a word-addressed memory with a 1-cycle
//                registered read and a synchronous write. Hits are served with
//                zero wait cycles. A miss stalls the CPU, writes back a dirty
//                victim line word by word, then refills the line word by word.
//                Access and miss counters support benchmark runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache #(
    parameter  int LINE_ADDR_LEN = 2,
    parameter  int SET_ADDR_LEN  = 3,
    parameter  int TAG_ADDR_LEN  = 6,
    localparam int MEM_ADDR_LEN  = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    miss,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic                    mem_wr_req,
    output logic [31:0]             mem_wr_data,
    input  logic [31:0]             mem_rd_data,
    output logic [31:0]             access_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int c_line_words = 1 << LINE_ADDR_LEN;
    localparam int c_sets       = 1 << SET_ADDR_LEN;
    localparam int c_words      = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);

    // Counter end points: SWAP_OUT runs k = 0..N-1, SWAP_IN runs k = 0..N
    localparam logic [LINE_ADDR_LEN:0]   c_cnt_last_out = (LINE_ADDR_LEN+1)'(c_line_words - 1);
    localparam logic [LINE_ADDR_LEN:0]   c_cnt_last_in  = (LINE_ADDR_LEN+1)'(c_line_words);
    localparam logic [LINE_ADDR_LEN:0]   c_cnt_one      = (LINE_ADDR_LEN+1)'(1);
    localparam logic [LINE_ADDR_LEN-1:0] c_off_one      = LINE_ADDR_LEN'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SWAP_OUT   = 2'd1,
        S_SWAP_IN    = 2'd2,
        S_SWAP_IN_OK = 2'd3
    } state_t;

    state_t                   r_state;
    logic [LINE_ADDR_LEN:0]   r_cnt;
    logic [c_sets-1:0]        r_valid;
    logic [c_sets-1:0]        r_dirty;
    logic [TAG_ADDR_LEN-1:0]  r_tag  [c_sets];
    logic [31:0]              r_data [c_words];
    logic [31:0]              r_access_cnt;
    logic [31:0]              r_miss_cnt;

    logic [MEM_ADDR_LEN-1:0]               w_word_idx;
    logic [LINE_ADDR_LEN-1:0]              w_offset;
    logic [SET_ADDR_LEN-1:0]               w_set;
    logic [TAG_ADDR_LEN-1:0]               w_tag;
    logic                                  w_req;
    logic                                  w_idle;
    logic                                  w_hit;
    logic                                  w_miss;
    logic                                  w_victim_dirty;
    logic [LINE_ADDR_LEN-1:0]              w_cnt_off;
    logic [LINE_ADDR_LEN-1:0]              w_fill_off;
    logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] w_hit_idx;
    logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] w_out_idx;
    logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] w_fill_idx;
    logic                                  w_unused;

    // Byte offset and address bits above the memory range carry no meaning
    assign w_unused = &{1'b0, addr[31:MEM_ADDR_LEN+2], addr[1:0]};

    assign w_word_idx = addr[MEM_ADDR_LEN+1:2];
    assign w_offset   = w_word_idx[LINE_ADDR_LEN-1:0];
    assign w_set      = w_word_idx[LINE_ADDR_LEN+SET_ADDR_LEN-1:LINE_ADDR_LEN];
    assign w_tag      = w_word_idx[MEM_ADDR_LEN-1:LINE_ADDR_LEN+SET_ADDR_LEN];

    assign w_req          = rd_req | wr_req;
    assign w_idle         = (r_state == S_IDLE);
    assign w_hit          = w_req && r_valid[w_set] && (r_tag[w_set] == w_tag) && w_idle;
    assign w_miss         = !w_idle || (w_req && !w_hit);
    assign w_victim_dirty = r_valid[w_set] && r_dirty[w_set];

    // Refill data arrives one cycle after its address, so it lands at k-1
    assign w_cnt_off  = r_cnt[LINE_ADDR_LEN-1:0];
    assign w_fill_off = w_cnt_off - c_off_one;
    assign w_hit_idx  = {w_set, w_offset};
    assign w_out_idx  = {w_set, w_cnt_off};
    assign w_fill_idx = {w_set, w_fill_off};

    assign miss       = w_miss;
    assign access_cnt = r_access_cnt;
    assign miss_cnt   = r_miss_cnt;

    // CPU read data and memory command decode for the current state
    always_comb begin
        rd_data     = 32'd0;
        mem_addr    = '0;
        mem_wr_req  = 1'b0;
        mem_wr_data = 32'd0;
        if (w_hit && !wr_req) begin
            rd_data = r_data[w_hit_idx];
        end
        case (r_state)
            S_SWAP_OUT: begin
                mem_addr    = {r_tag[w_set], w_set, w_cnt_off};
                mem_wr_req  = 1'b1;
                mem_wr_data = r_data[w_out_idx];
            end
            S_SWAP_IN: begin
                if (r_cnt != c_cnt_last_in) begin
                    mem_addr = {w_tag, w_set, w_cnt_off};
                end
            end
            default: begin
            end
        endcase
    end

    // Miss-handling state machine, line status bits and benchmark counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_access_cnt <= 32'd0;
            r_miss_cnt   <= 32'd0;
        end else begin
            if (w_req && !w_miss) begin
                r_access_cnt <= r_access_cnt + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_hit && wr_req) begin
                        r_dirty[w_set] <= 1'b1;
                    end else if (w_req && !w_hit) begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_cnt      <= '0;
                        r_state    <= w_victim_dirty ? S_SWAP_OUT : S_SWAP_IN;
                    end
                end
                S_SWAP_OUT: begin
                    if (r_cnt == c_cnt_last_out) begin
                        r_cnt   <= '0;
                        r_state <= S_SWAP_IN;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_SWAP_IN: begin
                    if (r_cnt == c_cnt_last_in) begin
                        r_state <= S_SWAP_IN_OK;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_SWAP_IN_OK: begin
                    r_valid[w_set] <= 1'b1;
                    r_dirty[w_set] <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage; contents survive reset, validity is what is cleared
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_hit && wr_req) begin
                r_data[w_hit_idx] <= wr_data;
            end
            if ((r_state == S_SWAP_IN) && (r_cnt != '0)) begin
                r_data[w_fill_idx] <= mem_rd_data;
            end
            if (r_state == S_SWAP_IN_OK) begin
                r_tag[w_set] <= w_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache
//  Description : Self-checking bench for dm_cache with a word-addressed
//                memory model, directed vector table, reset-abort sequence,
//                full sweep and randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic [10:0] mem_addr;
    logic        mem_wr_req;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic [31:0] access_cnt;
    logic [31:0] miss_cnt;

    logic        mem_load;
    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] tr_addr [0:31];
    bit          tr_we   [0:31];
    int          tr_n;

    // Reference model: CPU-visible memory image plus per-set occupancy
    logic [31:0] golden [0:2047];
    bit          m_valid [0:7];
    bit          m_dirty [0:7];
    int          m_tag   [0:7];
    int          exp_mc;
    int          exp_ac;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_mc;
        int          exp_ac;
        bit          chk_tr;
        bit          dv;
        int          vb;
        int          fb;
    } vec_t;

    vec_t tbl [0:7];

    dm_cache dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_addr    (mem_addr),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .access_cnt  (access_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read (old data on same-address write), synchronous write
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 2048; i++) mem[i] = i * 24;
        end else begin
            mem_rd_data <= mem[mem_addr];
            if (mem_wr_req) mem[mem_addr] = mem_wr_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync_model();
        for (int w = 0; w < 2048; w++) golden[w] = mem[w];
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = 0;
        end
        exp_mc = 0;
        exp_ac = 0;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sync_model();
    endtask

    task automatic model_access(input bit we, input int w, input logic [31:0] wd,
                                output logic [31:0] erd, output int est);
        int s;
        int t;
        s = (w / 4) % 8;
        t = w / 32;
        if (m_valid[s] && m_tag[s] == t) begin
            est = 0;
        end else begin
            est        = (m_valid[s] && m_dirty[s]) ? 11 : 7;
            exp_mc     = exp_mc + 1;
            m_valid[s] = 1'b1;
            m_tag[s]   = t;
            m_dirty[s] = 1'b0;
        end
        exp_ac = exp_ac + 1;
        if (we) begin
            golden[w]  = wd;
            m_dirty[s] = 1'b1;
            erd        = 32'd0;
        end else begin
            erd = golden[w];
        end
    endtask

    // Issue one request and hold it until served; records memory traffic while stalled
    task automatic cpu_access(input bit we, input bit both, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rdat, output int stall);
        bit done;
        addr    = a;
        wr_data = wd;
        wr_req  = we;
        rd_req  = !we || both;
        stall   = 0;
        tr_n    = 0;
        rdat    = 32'd0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!miss) begin
                rdat = rd_data;
                done = 1'b1;
            end else begin
                if (tr_n < 32) begin
                    tr_addr[tr_n] = mem_addr;
                    tr_we[tr_n]   = mem_wr_req;
                    tr_n++;
                end
                stall++;
                if (stall > 40) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL timeout: miss high for %0d cycles, expected at most 11", stall);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic check_trace(input string name, input bit dv, input int vb, input int fb);
        logic [10:0] ea [0:31];
        bit          ew [0:31];
        int          n;
        int          bad;
        n   = 0;
        bad = 0;
        ea[n] = 11'd0; ew[n] = 1'b0; n++;
        if (dv) begin
            for (int k = 0; k < 4; k++) begin
                ea[n] = 11'(vb + k); ew[n] = 1'b1; n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            ea[n] = 11'(fb + k); ew[n] = 1'b0; n++;
        end
        ea[n] = 11'd0; ew[n] = 1'b0; n++;
        ea[n] = 11'd0; ew[n] = 1'b0; n++;
        n_checks++;
        if (tr_n != n) begin
            bad = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (tr_addr[i] !== ea[i] || tr_we[i] != ew[i]) bad++;
            end
        end
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s: got %0d stall cycles with %0d wrong addr/we entries, expected %0d cycles all matching",
                     name, tr_n, bad, n);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] erd;
    int          st;
    int          est;
    int          w;
    bit          we;
    bit          both;
    logic [31:0] wd;
    logic [31:0] a;
    int          bad;
    int          s;
    int          t;

    initial begin
        //           we    addr       wdata         exp_rd        stall mc ac trace dv  vb  fb
        tbl[0] = '{1'b0, 32'h14,  32'h0,        32'h78,        7, 1, 1, 1'b1, 1'b0, 0, 4};
        tbl[1] = '{1'b0, 32'h14,  32'h0,        32'h78,        0, 1, 2, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b1, 32'h14,  32'hDEADBEEF, 32'h0,         0, 1, 3, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 32'h94,  32'h0,        32'h378,      11, 2, 4, 1'b1, 1'b1, 4, 32'h24};
        tbl[4] = '{1'b1, 32'h200, 32'h1234,     32'h0,         7, 3, 5, 1'b1, 1'b0, 0, 32'h80};
        tbl[5] = '{1'b0, 32'h200, 32'h0,        32'h1234,      0, 3, 6, 1'b0, 1'b0, 0, 0};
        tbl[6] = '{1'b0, 32'h94,  32'h0,        32'h378,       0, 3, 7, 1'b0, 1'b0, 0, 0};
        tbl[7] = '{1'b0, 32'h14,  32'h0,        32'hDEADBEEF,  7, 4, 8, 1'b1, 1'b0, 0, 4};

        addr     = 32'd0;
        wr_data  = 32'd0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        rst      = 1'b1;
        mem_load = 1'b1;
        @(posedge clk); #1;
        mem_load = 1'b0;
        reset_dut();

        // Reset state with no request
        @(negedge clk);
        check("rst_miss", {31'd0, miss}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        check("rst_access_cnt", access_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk); #1;

        // Directed vectors: clean miss, hit, write hit, dirty miss, write-allocate
        for (int i = 0; i < 8; i++) begin
            cpu_access(tbl[i].we, 1'b0, tbl[i].a, tbl[i].wd, rd, st);
            check($sformatf("vec%0d_rd_data", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
            check($sformatf("vec%0d_miss_cnt", i), miss_cnt, tbl[i].exp_mc);
            check($sformatf("vec%0d_access_cnt", i), access_cnt, tbl[i].exp_ac);
            if (tbl[i].chk_tr) check_trace($sformatf("vec%0d_mem_trace", i), tbl[i].dv, tbl[i].vb, tbl[i].fb);
        end
        check("writeback_word_005", mem[5], 32'hDEADBEEF);
        check("alloc_not_written_080", mem[128], 32'h00000C00);

        // Reset while the refill is in its second cycle
        addr   = 32'h40;
        rd_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("swapin_k1_mem_addr", {21'd0, mem_addr}, 32'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_mem_addr", {21'd0, mem_addr}, 32'd0);
        check("abort_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("abort_miss_cold", {31'd0, miss}, 32'd1);
        check("abort_miss_cnt", miss_cnt, 32'd0);
        check("abort_access_cnt", access_cnt, 32'd0);
        rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sync_model();
        cpu_access(1'b0, 1'b0, 32'h40, 32'd0, rd, st);
        check("reread_stall", st, 7);
        check("reread_rd_data", rd, 32'h180);
        cpu_access(1'b0, 1'b0, 32'h14, 32'd0, rd, st);
        check("invalidated_stall", st, 7);
        check("invalidated_rd_data", rd, 32'hDEADBEEF);
        cpu_access(1'b0, 1'b0, 32'h200, 32'd0, rd, st);
        check("lost_dirty_stall", st, 7);
        check("lost_dirty_rd_data", rd, 32'h00000C00);
        check("post_abort_miss_cnt", miss_cnt, 32'd3);
        check("post_abort_access_cnt", access_cnt, 32'd3);

        // Sequential sweep over 256 words
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            cpu_access(1'b0, 1'b0, 32'(i) << 2, 32'd0, rd, st);
            check($sformatf("sweep%0d_rd_data", i), rd, golden[i]);
            check($sformatf("sweep%0d_stall", i), st, ((i % 4) == 0) ? 7 : 0);
        end
        check("sweep_miss_cnt", miss_cnt, 32'd64);
        check("sweep_access_cnt", access_cnt, 32'd256);

        // Randomized traffic with heavy set conflicts
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            w    = $urandom_range(0, 127);
            we   = ($urandom_range(0, 1) == 1);
            both = we && ($urandom_range(0, 3) == 0);
            wd   = $urandom;
            a    = ($urandom & 32'hFFFF_E000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
            model_access(we, w, wd, erd, est);
            cpu_access(we, both, a, wd, rd, st);
            check($sformatf("rand%0d_rd_data", i), rd, erd);
            check($sformatf("rand%0d_stall", i), st, est);
            check($sformatf("rand%0d_access_cnt", i), access_cnt, exp_ac);
            check($sformatf("rand%0d_miss_cnt", i), miss_cnt, exp_mc);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                check($sformatf("rand%0d_idle_miss", i), {31'd0, miss}, 32'd0);
                check($sformatf("rand%0d_idle_rd_data", i), rd_data, 32'd0);
                @(posedge clk); #1;
            end
        end

        // Memory must agree with the model except where a dirty line still holds newer data
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            s = (k / 4) % 8;
            t = k / 32;
            if (!(m_valid[s] && m_dirty[s] && m_tag[s] == t) && mem[k] !== golden[k]) bad++;
        end
        check("mem_coherent_words_wrong", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
